// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, empty/full flags and occupancy count.
// Writes when full and reads when empty are dropped without touching any state.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32,
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH:0] DEPTH_COUNT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic                  wr_ok;
  logic                  rd_ok;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_COUNT);
  assign wr_ok = wen && !full;
  assign rd_ok = ren && !empty;

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!rst_n && wr_ok) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      rdata <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + ADDR_WIDTH'(1);
      end
      if (rd_ok) begin
        rdata <= mem[rptr];
        rptr  <= rptr + ADDR_WIDTH'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized self-checking bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst_n;
  logic          ren;
  logic [DW-1:0] rdata;
  logic          empty;
  logic          wen;
  logic [DW-1:0] wdata;
  logic          full;
  logic [AW:0]   count;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_rdata;

  sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ren   (ren),
    .rdata (rdata),
    .empty (empty),
    .wen   (wen),
    .wdata (wdata),
    .full  (full),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus, advance the model on pre-edge state, then settle past the edge.
  task automatic cycle(input logic rst, input logic w, input logic r, input logic [DW-1:0] d);
    bit can_wr;
    bit can_rd;
    rst_n = rst;
    wen   = w;
    ren   = r;
    wdata = d;
    can_wr = w && (model_q.size() < DEPTH);
    can_rd = r && (model_q.size() != 0);
    if (rst) begin
      model_q.delete();
      model_rdata = '0;
    end else begin
      if (can_rd) model_rdata = model_q.pop_front();
      if (can_wr) model_q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 1'b1, 8'h5A);
    cycle(1'b1, 1'b1, 1'b1, 8'h5A);
    tests_run++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: empty=%b full=%b, expected empty=1 full=0", empty, full);
    end
    tests_run++;
    if (count !== '0 || rdata !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: count=%0d rdata=%h, expected 0 and 00", count, rdata);
    end
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    tests_run++;
    if (count !== '0 || empty !== 1'b1 || rdata !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_nothing_stored: count=%0d empty=%b rdata=%h, expected 0 1 00", count, empty, rdata);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'(10 + i));
      tests_run++;
      if (count !== (AW + 1)'(i + 1) || empty !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL fill_count[%0d]: count=%0d empty=%b, expected %0d 0", i, count, empty, i + 1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      tests_run++;
      if (rdata !== 8'(10 + i) || count !== (AW + 1)'(2 - i)) begin
        tests_failed++;
        $display("[TB] FAIL drain[%0d]: rdata=%0d count=%0d, expected %0d %0d", i, rdata, count, 10 + i, 2 - i);
      end
    end
    tests_run++;
    if (empty !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL drain_empty: empty=%b, expected 1", empty);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] stream_in [5]  = '{8'd13, 8'd14, 8'd65, 8'd22, 8'd13};
    logic [DW-1:0] stream_out [5] = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14};
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'(10 + i));
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b1, stream_in[i]);
      tests_run++;
      if (rdata !== stream_out[i] || count !== (AW + 1)'(3)) begin
        tests_failed++;
        $display("[TB] FAIL stream[%0d]: rdata=%0d count=%0d, expected %0d 3", i, rdata, count, stream_out[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      tests_run++;
      if (rdata !== model_rdata) begin
        tests_failed++;
        $display("[TB] FAIL stream_tail[%0d]: rdata=%0d, expected %0d", i, rdata, model_rdata);
      end
    end
    tests_run++;
    if (empty !== 1'b1 || count !== '0) begin
      tests_failed++;
      $display("[TB] FAIL stream_empty: empty=%b count=%0d, expected 1 0", empty, count);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 8'(i));
    tests_run++;
    if (full !== 1'b1 || count !== (AW + 1)'(DEPTH)) begin
      tests_failed++;
      $display("[TB] FAIL full_flag: full=%b count=%0d, expected 1 %0d", full, count, DEPTH);
    end
    cycle(1'b0, 1'b1, 1'b0, 8'hFF);
    tests_run++;
    if (full !== 1'b1 || count !== (AW + 1)'(DEPTH)) begin
      tests_failed++;
      $display("[TB] FAIL overflow_ignored: full=%b count=%0d, expected 1 %0d", full, count, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      tests_run++;
      if (rdata !== 8'(i)) begin
        tests_failed++;
        $display("[TB] FAIL full_drain[%0d]: rdata=%0d, expected %0d", i, rdata, i);
      end
    end
    tests_run++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL full_drained_empty: empty=%b full=%b, expected 1 0", empty, full);
    end
  endtask

  task automatic test_full_both();
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 8'($urandom));
    cycle(1'b0, 1'b1, 1'b1, 8'hAA);
    tests_run++;
    if (count !== (AW + 1)'(DEPTH - 1) || full !== 1'b0 || rdata !== model_rdata) begin
      tests_failed++;
      $display("[TB] FAIL full_both: count=%0d full=%b rdata=%h, expected %0d 0 %h", count, full, rdata, DEPTH - 1, model_rdata);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      tests_run++;
      if (rdata !== model_rdata) begin
        tests_failed++;
        $display("[TB] FAIL full_both_drain[%0d]: rdata=%h, expected %h", i, rdata, model_rdata);
      end
    end
    tests_run++;
    if (empty !== 1'b1 || count !== '0) begin
      tests_failed++;
      $display("[TB] FAIL full_both_empty: empty=%b count=%0d, expected 1 0 (0xAA must not be stored)", empty, count);
    end
  endtask

  task automatic test_underflow_wrap();
    logic [DW-1:0] held;
    bit            w;
    bit            r;
    held = model_rdata;
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    tests_run++;
    if (rdata !== held || count !== '0) begin
      tests_failed++;
      $display("[TB] FAIL underflow: rdata=%h count=%0d, expected %h 0", rdata, count, held);
    end
    for (int i = 0; i < 100; i++) begin
      w = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 45);
      cycle(1'b0, w, r, 8'($urandom));
      tests_run++;
      if (rdata !== model_rdata || count !== (AW + 1)'(model_q.size()) ||
          empty !== (model_q.size() == 0) || full !== (model_q.size() == DEPTH)) begin
        tests_failed++;
        $display("[TB] FAIL wrap[%0d]: rdata=%h count=%0d empty=%b full=%b, expected %h %0d", i, rdata, count, empty, full, model_rdata, model_q.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    cycle(1'b1, 1'b1, 1'b1, 8'h77);
    tests_run++;
    if (empty !== 1'b1 || count !== '0 || rdata !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid: empty=%b count=%0d rdata=%h, expected 1 0 00", empty, count, rdata);
    end
    cycle(1'b0, 1'b1, 1'b1, 8'hC3);
    tests_run++;
    if (rdata !== '0 || count !== (AW + 1)'(1)) begin
      tests_failed++;
      $display("[TB] FAIL no_bypass: rdata=%h count=%0d, expected 00 1", rdata, count);
    end
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    tests_run++;
    if (rdata !== 8'hC3 || empty !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL after_reset_read: rdata=%h empty=%b, expected c3 1", rdata, empty);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    wen   = 1'b0;
    ren   = 1'b0;
    wdata = '0;
    model_rdata = '0;
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_full();
    test_full_both();
    test_underflow_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock first-in/first-out buffer for DATA_WIDTH-bit words, FIFO_DEPTH entries deep. Used as a generic rate-decoupling buffer between a producer and a consumer in the same clock domain. It provides registered read data, empty/full flags and an occupancy count. Illegal operations (write when full, read when empty) are dropped safely.

Parameters:
DATA_WIDTH, 8, width of each stored word in bits.
FIFO_DEPTH, 32, number of entries; must be a power of two and at least 2.
ADDR_WIDTH, $clog2(FIFO_DEPTH), pointer/index width (derived; do not override).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  synchronous reset, active-high (asserted when 1, sampled on the rising clk edge; name retained per codebase convention).
ren  input  1  read request.
rdata  output  DATA_WIDTH  read data, registered.
empty  output  1  FIFO holds no entries.
wen  input  1  write request.
wdata  input  DATA_WIDTH  write data.
full  output  1  FIFO holds FIFO_DEPTH entries.
count  output  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (rst_n=1 at a clk rising edge):
  - write pointer, read pointer and count cleared to 0.
  - empty=1, full=0, rdata=0.
  - Storage array is not cleared.
  - Reset has priority over any concurrent ren/wen.
  - Reset mid-operation discards all contents; the FIFO is empty the cycle after.
- Effective operations:
  - wr_ok = wen && !full
  - rd_ok = ren && !empty
  - Both are evaluated against flag values before the edge.
- Write: on wr_ok, mem[wptr] <= wdata and wptr increments modulo FIFO_DEPTH (natural wrap at ADDR_WIDTH bits).
- Read: on rd_ok, rdata <= mem[rptr] and rptr increments modulo FIFO_DEPTH.
  - Read latency is 1 cycle: the word appears on rdata after the edge that accepted ren.
  - rdata holds its last value when no read is accepted.
- Ordering: words are read out in exactly the order they were written. No bypass: a read in the same cycle as a write to an empty FIFO is dropped; the written word is available from the next cycle.
- Count update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged when both or neither occur.
- Flags are registered or derived combinationally from count:
  - empty = (count==0)
  - full = (count==FIFO_DEPTH)
  - Both are valid in the same cycle as count.
- Boundary cases:
  - Write when full: ignored; no pointer, count or data change.
  - Read when empty: ignored; rdata unchanged.
  - Full with wen and ren both asserted: only the read happens; count becomes FIFO_DEPTH-1, full deasserts.
  - Non-full, non-empty with both asserted: both happen; count unchanged.
  - Pointer wrap: after FIFO_DEPTH writes and reads, pointers return to 0 and ordering is preserved.
- No X propagation on outputs after reset.

Test Plan:
1. Reset: hold rst_n=1 for 2 cycles with wen=ren=1 -> empty=1, full=0, count=0, rdata=0; nothing stored.
2. Fill then drain:
   - Release reset, write 10,11,12 on consecutive cycles -> count=1,2,3, empty=0 after the first write.
   - Then ren=1 for 3 cycles -> rdata=10,11,12 one cycle after each accepted read; count returns to 0, empty=1.
3. Simultaneous streaming:
   - Write 10,11,12, then wen=ren=1 with wdata 13,14,65,22,13 -> rdata sequence 10,11,12,13,14.
   - count holds at 3 throughout the overlap.
4. Full: write 32 words (0..31) -> full=1, count=32. A 33rd write (0xFF) is ignored. Draining yields 0..31 in order, then empty=1.
5. Full plus both requests: when full, assert wen=ren=1 with wdata=0xAA -> a read occurs, count=31, full=0, 0xAA is not stored.
6. Underflow and wrap:
   - ren=1 when empty -> rdata unchanged, count=0.
   - Then run 100 interleaved write/read operations -> data order preserved across pointer wrap.
